// File: rtl/err_evt_pkg.sv
// Shared defaults and the error record type for the error event collector.
package err_evt_pkg;

   localparam int N_SRC_DEF  = 4;
   localparam int CODE_W_DEF = 8;
   localparam int DEPTH_DEF  = 8;
   localparam int TS_W_DEF   = 16;
   localparam int CNT_W_DEF  = 8;
   localparam int SRC_W_DEF  = $clog2(N_SRC_DEF);

   // One queued error record at the default widths.
   typedef struct packed {
      logic [SRC_W_DEF-1:0]  src;
      logic [CODE_W_DEF-1:0] code;
      logic [TS_W_DEF-1:0]   ts;
   } err_rec_t;

endpackage

// File: rtl/err_rr_arbiter.sv
// Round-robin arbiter: grants one requester per enabled cycle, searching
// from a rotating pointer that moves just past the last winner.
module err_rr_arbiter #(
   parameter int N_SRC = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SRC-1:0]         req_i,
   input  logic                     en_i,
   output logic [N_SRC-1:0]         gnt_o,
   output logic [$clog2(N_SRC)-1:0] gnt_idx_o,
   output logic                     gnt_vld_o
);

   localparam int SRC_W = $clog2(N_SRC);

   logic [SRC_W-1:0] ptr_q, ptr_d;

   // Pick the first requester at or after ptr, wrapping around.
   always_comb begin
      int j;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      ptr_d     = ptr_q;
      j         = 0;
      if (en_i) begin
         for (int k = 0; k < N_SRC; k++) begin
            j = (int'(ptr_q) + k) % N_SRC;
            if (!gnt_vld_o && req_i[j]) begin
               gnt_vld_o = 1'b1;
               gnt_o[j]  = 1'b1;
               gnt_idx_o = SRC_W'(j);
            end
         end
      end
      if (gnt_vld_o) begin
         if (int'(gnt_idx_o) == N_SRC - 1) ptr_d = '0;
         else                              ptr_d = gnt_idx_o + SRC_W'(1);
      end
   end

   // Rotating priority pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/err_event_collector.sv
// Captures one-cycle checker error pulses, timestamps them, arbitrates them
// round-robin into a record FIFO and keeps first-error / drop status.
module err_event_collector
   import err_evt_pkg::*;
#(
   parameter int N_SRC  = N_SRC_DEF,
   parameter int CODE_W = CODE_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int TS_W   = TS_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_SRC-1:0]           err_valid,
   input  logic [N_SRC*CODE_W-1:0]    err_code,
   input  logic                       clear,
   output logic                       rec_valid,
   input  logic                       rec_ready,
   output logic [$clog2(N_SRC)-1:0]   rec_src,
   output logic [CODE_W-1:0]          rec_code,
   output logic [TS_W-1:0]            rec_ts,
   output logic                       err_any,
   output logic [$clog2(N_SRC)-1:0]   first_src,
   output logic [CODE_W-1:0]          first_code,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int SRC_W = $clog2(N_SRC);
   localparam int AW    = $clog2(DEPTH);

   logic [TS_W-1:0]   ts_q;
   logic [N_SRC-1:0]  pend_vld_q, pend_vld_d;
   logic [CODE_W-1:0] pend_code_q [N_SRC];
   logic [TS_W-1:0]   pend_ts_q   [N_SRC];
   logic [N_SRC-1:0]  cap, drop, gnt;
   logic [SRC_W-1:0]  gnt_idx;
   logic              gnt_vld;

   logic [SRC_W-1:0]  mem_src  [DEPTH];
   logic [CODE_W-1:0] mem_code [DEPTH];
   logic [TS_W-1:0]   mem_ts   [DEPTH];
   logic [AW:0]       wr_ptr_q, rd_ptr_q, level;
   logic              full, empty, rd_en;

   logic              err_any_q, err_any_d;
   logic [SRC_W-1:0]  first_src_q, first_src_d;
   logic [CODE_W-1:0] first_code_q, first_code_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);
   assign rd_en = !empty && rec_ready;

   err_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (pend_vld_q),
      .en_i     (!full),
      .gnt_o    (gnt),
      .gnt_idx_o(gnt_idx),
      .gnt_vld_o(gnt_vld)
   );

   // Per-source capture/drop decision; a grant this cycle frees the slot.
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         cap[i]  = err_valid[i] && (!pend_vld_q[i] || gnt[i]);
         drop[i] = err_valid[i] && pend_vld_q[i] && !gnt[i];
         if (cap[i])      pend_vld_d[i] = 1'b1;
         else if (gnt[i]) pend_vld_d[i] = 1'b0;
         else             pend_vld_d[i] = pend_vld_q[i];
      end
   end

   // Timestamp counter and pending registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q       <= '0;
         pend_vld_q <= '0;
         for (int i = 0; i < N_SRC; i++) begin
            pend_code_q[i] <= '0;
            pend_ts_q[i]   <= '0;
         end
      end else begin
         ts_q       <= ts_q + TS_W'(1);
         pend_vld_q <= pend_vld_d;
         for (int i = 0; i < N_SRC; i++) begin
            if (cap[i]) begin
               pend_code_q[i] <= err_code[i*CODE_W +: CODE_W];
               pend_ts_q[i]   <= ts_q;
            end
         end
      end
   end

   // FIFO storage; contents are only visible while rec_valid is high.
   always_ff @(posedge clk) begin
      if (gnt_vld) begin
         mem_src[wr_ptr_q[AW-1:0]]  <= gnt_idx;
         mem_code[wr_ptr_q[AW-1:0]] <= pend_code_q[gnt_idx];
         mem_ts[wr_ptr_q[AW-1:0]]   <= pend_ts_q[gnt_idx];
      end
   end

   // FIFO pointers with an extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (gnt_vld) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (rd_en)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Sticky status: clear first, then this cycle's captures and drops re-arm it.
   always_comb begin
      err_any_d    = clear ? 1'b0 : err_any_q;
      first_src_d  = clear ? '0   : first_src_q;
      first_code_d = clear ? '0   : first_code_q;
      drop_cnt_d   = clear ? '0   : drop_cnt_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (cap[i] && !err_any_d) begin
            err_any_d    = 1'b1;
            first_src_d  = SRC_W'(i);
            first_code_d = err_code[i*CODE_W +: CODE_W];
         end
         if (drop[i] && (drop_cnt_d != {CNT_W{1'b1}}))
            drop_cnt_d = drop_cnt_d + CNT_W'(1);
      end
   end

   // Status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_any_q    <= 1'b0;
         first_src_q  <= '0;
         first_code_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         err_any_q    <= err_any_d;
         first_src_q  <= first_src_d;
         first_code_q <= first_code_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign rec_valid  = !empty;
   assign rec_src    = rec_valid ? mem_src[rd_ptr_q[AW-1:0]]  : '0;
   assign rec_code   = rec_valid ? mem_code[rd_ptr_q[AW-1:0]] : '0;
   assign rec_ts     = rec_valid ? mem_ts[rd_ptr_q[AW-1:0]]   : '0;
   assign fifo_level = level;
   assign err_any    = err_any_q;
   assign first_src  = first_src_q;
   assign first_code = first_code_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
